// File: rtl/axis_rr_packet_arbiter_pkg.sv
// Shared types for the round-robin packet arbiter.
// Holds the arbiter state encoding and the grant-index width helper.
package axis_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_rr_packet_arbiter_if.sv
// Stream bundle for the arbiter: NUM_IN source streams in, one stream out.
// slave is the arbiter's view, master is the surrounding fabric's view.
interface axis_rr_packet_arbiter_if #(
    parameter int NUM_IN = 2,
    parameter int DATA_W = 8,
    parameter int ID_W   = 1
);

    logic [NUM_IN-1:0]        s_tvalid;
    logic [NUM_IN-1:0]        s_tlast;
    logic [NUM_IN*DATA_W-1:0] s_tdata;
    logic [NUM_IN-1:0]        s_tready;

    logic                     m_tvalid;
    logic                     m_tlast;
    logic [DATA_W-1:0]        m_tdata;
    logic [ID_W-1:0]          m_tid;
    logic                     m_tready;

    modport slave (
        input  s_tvalid,
        input  s_tlast,
        input  s_tdata,
        output s_tready,
        output m_tvalid,
        output m_tlast,
        output m_tdata,
        output m_tid,
        input  m_tready
    );

    modport master (
        output s_tvalid,
        output s_tlast,
        output s_tdata,
        input  s_tready,
        input  m_tvalid,
        input  m_tlast,
        input  m_tdata,
        input  m_tid,
        output m_tready
    );

endinterface

// File: rtl/axis_rr_packet_arbiter_skid.sv
// Two-entry skid buffer: entry0 drives the output, entry1 absorbs one beat.
// in_ready depends only on registered state, breaking the ready path.
module axis_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    logic         v0;
    logic         v1;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic         drain;
    logic         push;

    assign drain     = v0 & out_ready;
    assign push      = in_valid & in_ready;
    assign in_ready  = ~v1;
    assign out_valid = v0;
    assign out_data  = d0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
            d0 <= '0;
            d1 <= '0;
        end else begin
            if (drain) begin
                if (v1) begin
                    d0 <= d1;
                    v1 <= 1'b0;
                end else begin
                    v0 <= 1'b0;
                end
            end
            // a push is only possible with entry1 empty
            if (push) begin
                if (!v0 || drain) begin
                    v0 <= 1'b1;
                    d0 <= in_data;
                end else begin
                    v1 <= 1'b1;
                    d1 <= in_data;
                end
            end
        end
    end

endmodule

// File: rtl/axis_rr_packet_arbiter.sv
// Round-robin, packet-locked merge of NUM_IN streams onto one stream.
// Output registered through a skid buffer; m_tid carries the source index.
module axis_rr_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter  int NUM_IN = 2,
    parameter  int DATA_W = 8,
    localparam int ID_W   = id_width(NUM_IN)
) (
    input logic                      clk,
    input logic                      reset,
    axis_rr_packet_arbiter_if.slave  bus
);

    localparam int PAY_W = DATA_W + 1 + ID_W;

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic [ID_W-1:0]   grant_q;
    logic [ID_W-1:0]   grant_d;
    logic [ID_W-1:0]   rr_q;
    logic [ID_W-1:0]   rr_d;

    logic              skid_ready;
    logic              beat_in;
    logic              beat_acc;
    logic              beat_last;
    logic [DATA_W-1:0] beat_data;
    logic [NUM_IN-1:0] ready_vec;
    logic [PAY_W-1:0]  in_pay;
    logic [PAY_W-1:0]  out_pay;
    logic              out_valid;

    // first requester at or after ptr, wrapping
    function automatic logic [ID_W-1:0] rr_pick(
        input logic [NUM_IN-1:0] req,
        input logic [ID_W-1:0]   ptr
    );
        logic [ID_W-1:0] sel;
        logic            hit;
        int              idx;
        sel = '0;
        hit = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_IN) idx = idx - NUM_IN;
            if (!hit && req[idx]) begin
                sel = ID_W'(idx);
                hit = 1'b1;
            end
        end
        return sel;
    endfunction

    assign beat_data = bus.s_tdata[int'(grant_q)*DATA_W +: DATA_W];
    assign beat_last = bus.s_tlast[grant_q];
    assign beat_in   = (state_q == ARB_LOCKED) && bus.s_tvalid[grant_q];
    assign beat_acc  = beat_in & skid_ready;
    assign in_pay    = {beat_data, beat_last, grant_q};

    always_comb begin
        ready_vec = '0;
        if (state_q == ARB_LOCKED) ready_vec[grant_q] = skid_ready;
    end

    assign bus.s_tready = ready_vec;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (|bus.s_tvalid) begin
                    grant_d = rr_pick(bus.s_tvalid, rr_q);
                    state_d = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                if (beat_acc && beat_last) begin
                    state_d = ARB_IDLE;
                    if (int'(grant_q) == NUM_IN - 1) rr_d = '0;
                    else rr_d = grant_q + ID_W'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

    axis_skid_buffer #(
        .W (PAY_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (beat_in),
        .in_data   (in_pay),
        .in_ready  (skid_ready),
        .out_valid (out_valid),
        .out_data  (out_pay),
        .out_ready (bus.m_tready)
    );

    assign bus.m_tvalid = out_valid;
    assign bus.m_tdata  = out_pay[PAY_W-1 -: DATA_W];
    assign bus.m_tlast  = out_pay[ID_W];
    assign bus.m_tid    = out_pay[ID_W-1:0];

endmodule
